// File: rtl/keypad_pkg.sv
// Shared types and constants for the 4x4 keypad scan controller.
package keypad_pkg;

  localparam int NUM_ROWS = 4;
  localparam int NUM_COLS = 4;

  // Key code layout: {row_onehot[3:0], col_onehot[3:0]}, active-high.
  typedef logic [7:0] key_code_t;

  localparam key_code_t NO_KEY = 8'h00;

  typedef enum logic [1:0] {
    SCAN     = 2'd0,
    DEBOUNCE = 2'd1,
    HELD     = 2'd2,
    RELEASE  = 2'd3
  } state_t;

  // True when exactly one bit of a column pattern is set.
  function automatic logic is_onehot4(input logic [3:0] v);
    return (v != 4'b0000) && ((v & (v - 4'b0001)) == 4'b0000);
  endfunction

endpackage

// File: rtl/keypad_scan_controller_sync_2ff.sv
// Two-flop synchronizer for asynchronous inputs; resets to all ones so
// pulled-up column lines read as idle while in reset.
module sync_2ff #(
  parameter int W = 4
) (
  input  logic         i_clk,
  input  logic         i_rst_n,
  input  logic [W-1:0] i_d,
  output logic [W-1:0] o_q
);

  logic [W-1:0] r_meta;
  logic [W-1:0] r_sync;

  // Shift the raw input through two flops to resolve metastability.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_meta <= '1;
      r_sync <= '1;
    end else begin
      r_meta <= i_d;
      r_sync <= r_meta;
    end
  end

  assign o_q = r_sync;

endmodule

// File: rtl/keypad_scan_controller.sv
// Keypad scan controller: drives one row low at a time, freezes on a single
// pressed column, debounces press and release, and keeps a two-deep history.
// key_valid is a one-cycle strobe with no back-pressure: downstream must take
// most_recent_key/second_most_recent_key in the cycle key_valid is high or
// any later cycle before the next strobe.
module keypad_scan_controller
  import keypad_pkg::*;
#(
  parameter int SCAN_DWELL      = 24000,
  parameter int DEBOUNCE_CYCLES = 480000
) (
  input  logic      clk,
  input  logic      reset,
  input  logic [3:0] keypad_column,
  output logic [3:0] keypad_row,
  output logic      key_valid,
  output key_code_t most_recent_key,
  output key_code_t second_most_recent_key,
  output state_t    o_dbg_state
);

  localparam int DW = $clog2(SCAN_DWELL + 1);
  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [DW-1:0] DWELL_LAST = DW'(SCAN_DWELL - 1);
  localparam logic [CW-1:0] DEB_LAST   = CW'(DEBOUNCE_CYCLES - 1);
  localparam logic [CW-1:0] DEB_FULL   = CW'(DEBOUNCE_CYCLES);

  logic [3:0]    w_col_s;
  logic [3:0]    w_pressed;
  logic          w_cap_down;
  logic          w_match;
  logic [CW-1:0] w_cnt_inc;

  state_t        r_state,  w_state_nx;
  logic [1:0]    r_idx,    w_idx_nx;
  logic [DW-1:0] r_dwell,  w_dwell_nx;
  logic [CW-1:0] r_cnt,    w_cnt_nx;
  key_code_t     r_cap,    w_cap_nx;
  key_code_t     r_mr,     w_mr_nx;
  key_code_t     r_smr,    w_smr_nx;
  logic          r_valid,  w_valid_nx;
  logic [3:0]    r_row;
  logic          w_advance;

  sync_2ff #(.W(4)) u_col_sync (
    .i_clk   (clk),
    .i_rst_n (reset),
    .i_d     (keypad_column),
    .o_q     (w_col_s)
  );

  assign w_pressed  = ~w_col_s;
  assign w_match    = (w_pressed == r_cap[3:0]);
  assign w_cap_down = |(w_pressed & r_cap[3:0]);
  // Saturating increment so the counter can never wrap.
  assign w_cnt_inc  = (r_cnt == DEB_FULL) ? r_cnt : r_cnt + 1'b1;

  // Next-state, counter and history decisions for the scan/debounce FSM.
  always_comb begin
    w_state_nx = r_state;
    w_idx_nx   = r_idx;
    w_dwell_nx = r_dwell;
    w_cnt_nx   = r_cnt;
    w_cap_nx   = r_cap;
    w_mr_nx    = r_mr;
    w_smr_nx   = r_smr;
    w_valid_nx = 1'b0;
    w_advance  = 1'b0;
    case (r_state)
      SCAN: begin
        if (r_dwell == DWELL_LAST) begin
          w_dwell_nx = '0;
          if (is_onehot4(w_pressed)) begin
            w_cap_nx   = {4'b0001 << r_idx, w_pressed};
            w_cnt_nx   = '0;
            w_state_nx = DEBOUNCE;
          end else begin
            w_advance = 1'b1;
          end
        end else begin
          w_dwell_nx = r_dwell + 1'b1;
        end
      end
      DEBOUNCE: begin
        if (!w_match) begin
          w_state_nx = SCAN;
          w_advance  = 1'b1;
        end else begin
          w_cnt_nx = w_cnt_inc;
          if (r_cnt == DEB_LAST) begin
            w_valid_nx = 1'b1;
            w_smr_nx   = r_mr;
            w_mr_nx    = r_cap;
            w_state_nx = HELD;
          end
        end
      end
      HELD: begin
        // Only the captured column matters; extra columns are ignored.
        if (!w_cap_down) begin
          w_cnt_nx   = '0;
          w_state_nx = RELEASE;
        end
      end
      RELEASE: begin
        if (w_cap_down) begin
          w_cnt_nx   = '0;
          w_state_nx = HELD;
        end else if (r_cnt == DEB_LAST) begin
          w_state_nx = SCAN;
          w_advance  = 1'b1;
        end else begin
          w_cnt_nx = w_cnt_inc;
        end
      end
      default: begin
        w_state_nx = SCAN;
        w_advance  = 1'b1;
      end
    endcase
    if (w_advance) begin
      w_idx_nx   = r_idx + 2'd1;
      w_dwell_nx = '0;
      w_cnt_nx   = '0;
    end
  end

  // State, counters, row drive and history registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= SCAN;
      r_idx   <= 2'd0;
      r_dwell <= '0;
      r_cnt   <= '0;
      r_cap   <= NO_KEY;
      r_mr    <= NO_KEY;
      r_smr   <= NO_KEY;
      r_valid <= 1'b0;
      r_row   <= 4'b1110;
    end else begin
      r_state <= w_state_nx;
      r_idx   <= w_idx_nx;
      r_dwell <= w_dwell_nx;
      r_cnt   <= w_cnt_nx;
      r_cap   <= w_cap_nx;
      r_mr    <= w_mr_nx;
      r_smr   <= w_smr_nx;
      r_valid <= w_valid_nx;
      r_row   <= ~(4'b0001 << w_idx_nx);
    end
  end

  assign keypad_row             = r_row;
  assign key_valid              = r_valid;
  assign most_recent_key        = r_mr;
  assign second_most_recent_key = r_smr;
  assign o_dbg_state            = r_state;

endmodule

// File: tb/tb_keypad_scan_controller.sv
// Bench for keypad_scan_controller with a simulated key matrix, a procedural
// reference thread, a per-cycle compare process and directed scenarios.
module tb_keypad_scan_controller;
  import keypad_pkg::*;

  localparam int SD = 4;
  localparam int DC = 8;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  logic [3:0] keypad_column;
  logic [3:0] keypad_row;
  logic       key_valid;
  key_code_t  most_recent_key;
  key_code_t  second_most_recent_key;
  state_t     o_dbg_state;

  keypad_scan_controller #(.SCAN_DWELL(SD), .DEBOUNCE_CYCLES(DC)) dut (
    .clk                    (clk),
    .reset                  (reset),
    .keypad_column          (keypad_column),
    .keypad_row             (keypad_row),
    .key_valid              (key_valid),
    .most_recent_key        (most_recent_key),
    .second_most_recent_key (second_most_recent_key),
    .o_dbg_state            (o_dbg_state)
  );

  // ---------------- physical key matrix ----------------
  logic [3:0] keys [0:3];
  initial for (int r = 0; r < 4; r++) keys[r] = 4'b0000;

  always_comb begin
    logic [3:0] w;
    w = 4'hF;
    for (int r = 0; r < 4; r++)
      if (!keypad_row[r]) w = w & ~keys[r];
    keypad_column = w;
  end

  // ---------------- reference model ----------------
  logic [3:0] m_row   = 4'b1110;
  logic       m_valid = 1'b0;
  key_code_t  m_mr    = 8'h00;
  key_code_t  m_smr   = 8'h00;
  logic [3:0] m_s1, m_s2;

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      m_s1 <= 4'hF;
      m_s2 <= 4'hF;
    end else begin
      m_s1 <= keypad_column;
      m_s2 <= m_s1;
    end
  end

  function automatic logic [3:0] row_bit(input int i);
    logic [3:0] r;
    r = 4'b0000;
    r[i[1:0]] = 1'b1;
    return r;
  endfunction

  task automatic tick(output bit ab);
    @(posedge clk);
    ab = (reset == 1'b0);
  endtask

  task automatic model_reset();
    m_row = 4'b1110; m_valid = 1'b0; m_mr = 8'h00; m_smr = 8'h00;
  endtask

  // Walks the rules as sequential phases: dwell per row, count stable
  // press cycles, then wait for a full stable release.
  task automatic model_run();
    int idx; int n; bit ab; bit got; bit done;
    logic [3:0] p; key_code_t cap;
    idx = 0; cap = 8'h00;
    forever begin
      got = 1'b0;
      while (!got) begin
        for (int d = 0; d < SD; d++) begin
          tick(ab); if (ab) begin model_reset(); return; end
          m_valid = 1'b0;
          p = ~m_s2;
          if (d == SD - 1) begin
            if ($countones(p) == 1) begin
              cap = {row_bit(idx), p}; got = 1'b1;
            end else begin
              idx = (idx + 1) % 4; m_row = ~row_bit(idx);
            end
          end
        end
      end
      n = 0;
      while (n < DC) begin
        tick(ab); if (ab) begin model_reset(); return; end
        if (~m_s2 == cap[3:0]) n++; else break;
      end
      if (n < DC) begin
        idx = (idx + 1) % 4; m_row = ~row_bit(idx);
        continue;
      end
      m_valid = 1'b1; m_smr = m_mr; m_mr = cap;
      done = 1'b0;
      while (!done) begin
        do begin
          tick(ab); if (ab) begin model_reset(); return; end
          m_valid = 1'b0;
        end while ((~m_s2 & cap[3:0]) != 4'b0000);
        n = 0;
        while (n < DC) begin
          tick(ab); if (ab) begin model_reset(); return; end
          m_valid = 1'b0;
          if ((~m_s2 & cap[3:0]) == 4'b0000) n++; else break;
        end
        if (n == DC) done = 1'b1;
      end
      idx = (idx + 1) % 4; m_row = ~row_bit(idx);
    end
  endtask

  initial begin
    forever begin
      wait (reset === 1'b1);
      model_run();
    end
  end

  // ---------------- scoreboard ----------------
  int n_cmp = 0;
  int n_bad = 0;

  always @(negedge clk) begin
    logic [20:0] act, exp;
    act = {keypad_row, key_valid, most_recent_key, second_most_recent_key};
    if (!reset) exp = {4'b1110, 1'b0, 8'h00, 8'h00};
    else        exp = {m_row, m_valid, m_mr, m_smr};
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL cycle_outputs t=%0t got row=%b v=%b mr=%h smr=%h required row=%b v=%b mr=%h smr=%h",
               $time, act[20:17], act[16], act[15:8], act[7:0],
               exp[20:17], exp[16], exp[15:8], exp[7:0]);
    end
  end

  // Counts key_valid pulses and records press-to-strobe latency.
  int     cyc = 0;
  int     valid_cnt = 0;
  int     t_deb = 0;
  int     t_valid = 0;
  state_t prev_state = SCAN;
  always @(negedge clk) begin
    cyc++;
    if (reset) begin
      if (o_dbg_state == DEBOUNCE && prev_state != DEBOUNCE) t_deb = cyc;
      if (key_valid) begin valid_cnt++; t_valid = cyc; end
    end
    prev_state = o_dbg_state;
  end

  // ---------------- driver / check tasks ----------------
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h required %0h", name, act, exp);
    end
  endtask

  task automatic wait_state(input state_t s, input int budget, input string name);
    int k;
    k = 0;
    while (o_dbg_state != s && k < budget) begin @(negedge clk); k++; end
    n_cmp++;
    if (o_dbg_state != s) begin
      n_bad++;
      $display("FAIL %s: timeout, state %0d required %0d", name, o_dbg_state, s);
    end
  endtask

  task automatic wait_row(input logic [3:0] r, input int budget, input string name);
    int k;
    k = 0;
    while (keypad_row != r && k < budget) begin @(negedge clk); k++; end
    n_cmp++;
    if (keypad_row != r) begin
      n_bad++;
      $display("FAIL %s: timeout, row %b required %b", name, keypad_row, r);
    end
  endtask

  task automatic cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  // ---------------- directed scenarios ----------------
  initial begin
    int base;
    cycles(3);
    check("reset_row", 32'(keypad_row), 32'h E);
    check("reset_mr", 32'(most_recent_key), 32'h0);
    reset = 1'b1;

    // Idle scan: row steps every SD cycles.
    cycles(4);  check("idle_row1", 32'(keypad_row), 32'h D);
    cycles(4);  check("idle_row2", 32'(keypad_row), 32'h B);
    cycles(4);  check("idle_row3", 32'(keypad_row), 32'h 7);
    cycles(4);  check("idle_row0", 32'(keypad_row), 32'h E);
    check("idle_no_valid", 32'(valid_cnt), 32'd0);

    // Clean press row 2 col 1.
    base = valid_cnt;
    keys[2] = 4'b0010;
    wait_state(HELD, 200, "press42_held");
    check("press42_row_frozen", 32'(keypad_row), 32'h B);
    cycles(1);
    check("press42_mr", 32'(most_recent_key), 32'h42);
    check("press42_smr", 32'(second_most_recent_key), 32'h00);
    check("press42_one_pulse", 32'(valid_cnt - base), 32'd1);
    check("press42_latency", 32'(t_valid - t_deb), 32'd8);
    cycles(20);
    check("press42_held_no_repeat", 32'(valid_cnt - base), 32'd1);
    keys[2] = 4'b0000;
    wait_state(SCAN, 200, "release42_scan");

    // Bounce during debounce.
    base = valid_cnt;
    keys[2] = 4'b0010;
    wait_state(DEBOUNCE, 200, "bounce_deb");
    cycles(3);
    keys[2] = 4'b0000;
    cycles(2);
    keys[2] = 4'b0010;
    wait_state(SCAN, 20, "bounce_back_scan");
    check("bounce_row3", 32'(keypad_row), 32'h 7);
    check("bounce_no_valid", 32'(valid_cnt - base), 32'd0);
    wait_state(HELD, 200, "bounce_then_held");
    cycles(1);
    check("bounce_single_reg", 32'(valid_cnt - base), 32'd1);
    check("bounce_smr", 32'(second_most_recent_key), 32'h42);
    keys[2] = 4'b0000;
    wait_state(SCAN, 200, "bounce_release");

    // Long hold row 0 col 3 with extra column and a release bounce.
    base = valid_cnt;
    keys[0] = 4'b1000;
    wait_state(HELD, 200, "hold18_held");
    cycles(40);
    keys[0] = 4'b1010;
    cycles(20);
    keys[0] = 4'b1000;
    cycles(40);
    keys[0] = 4'b0000;
    wait_state(RELEASE, 20, "hold18_release");
    cycles(2);
    keys[0] = 4'b1000;
    cycles(3);
    keys[0] = 4'b0000;
    wait_state(SCAN, 200, "hold18_scan");
    check("hold18_one_pulse", 32'(valid_cnt - base), 32'd1);
    check("hold18_mr", 32'(most_recent_key), 32'h18);
    keys[3] = 4'b0001;
    wait_state(HELD, 200, "press81_held");
    cycles(1);
    check("press81_mr", 32'(most_recent_key), 32'h81);
    check("press81_smr", 32'(second_most_recent_key), 32'h18);
    keys[3] = 4'b0000;
    wait_state(SCAN, 200, "press81_release");

    // Two columns in row 1 at the sample: no capture.
    base = valid_cnt;
    keys[1] = 4'b0101;
    wait_row(4'b1110, 40, "multi_wait_row0");
    wait_row(4'b1101, 40, "multi_wait_row1");
    cycles(4);
    check("multi_row2", 32'(keypad_row), 32'h B);
    check("multi_state_scan", 32'(o_dbg_state), 32'(SCAN));
    keys[1] = 4'b0000;
    cycles(8);
    check("multi_no_valid", 32'(valid_cnt - base), 32'd0);

    // Reset while HELD.
    keys[2] = 4'b0100;
    wait_state(HELD, 200, "rst_held");
    cycles(1);
    check("rst_pre_mr", 32'(most_recent_key), 32'h44);
    @(posedge clk);
    #2 reset = 1'b0;
    #1;
    check("rst_async_row", 32'(keypad_row), 32'h E);
    check("rst_async_valid", 32'(key_valid), 32'd0);
    check("rst_async_mr", 32'(most_recent_key), 32'h00);
    check("rst_async_smr", 32'(second_most_recent_key), 32'h00);
    check("rst_async_state", 32'(o_dbg_state), 32'(SCAN));
    keys[2] = 4'b0000;
    cycles(3);
    reset = 1'b1;
    cycles(3);
    check("rst_restart_row0", 32'(keypad_row), 32'h E);
    cycles(1);
    check("rst_restart_row1", 32'(keypad_row), 32'h D);

    cycles(5);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/keypad_scan_controller.md
# keypad_scan_controller

Sequencing controller for the 4x4 keypad. It walks an active-low drive across the keypad rows and synchronizes the column inputs. On a single-key press it freezes the scan, debounces the press, and registers it exactly once. It then holds until a debounced release and maintains the two-deep key history that feeds the digit converters and 7-segment multiplexer downstream. It runs on the divided 24 MHz system clock.

## Interface
Parameters:
- SCAN_DWELL, default 24000: cycles each row is driven before its columns are sampled (1 ms at 24 MHz); must be ≥ 3.
- DEBOUNCE_CYCLES, default 480000: consecutive stable cycles required to accept a press or a release (20 ms).

Ports:
- clk, input, 1: system clock; single clock domain.
- reset, input, 1: asynchronous, active-low reset.
- keypad_column, input, 4: raw column lines; pulled up, so a low bit means that column is connected to the driven row.
- keypad_row, output, 4: row drive; exactly one bit is low at all times.
- key_valid, output, 1: one-cycle pulse when a debounced press is registered.
- most_recent_key, output, 8: latest key code.
- second_most_recent_key, output, 8: previous key code.

## Operation
- Key code is {row_onehot[3:0], col_onehot[3:0]}, active-high.
  - Example: row 2, col 1 is 8'b0100_0010.
  - NO_KEY = 8'h00.
- keypad_column passes through a 2-flop synchronizer. All decisions use the synchronized value `col_s`.
- Columns pressed is defined as ~col_s.
- State SCAN:
  - The row index cycles 0→1→2→3→0.
  - keypad_row = ~(4'b0001 << idx).
  - A dwell counter runs 0..SCAN_DWELL-1. The sample is taken on the cycle the counter equals SCAN_DWELL-1.
  - Sample shows exactly one column pressed: capture {row, col} and go to DEBOUNCE. The row drive stays frozen.
  - Sample shows zero or ≥2 columns pressed: advance the row and clear the dwell counter.
- State DEBOUNCE:
  - The counter increments on each cycle in which the pressed-column pattern equals the captured pattern.
  - Any mismatch: return to SCAN, advance to the next row, clear counters. Nothing is registered.
  - Counter reaches DEBOUNCE_CYCLES:
    - key_valid pulses for one cycle.
    - second_most_recent_key ← most_recent_key.
    - most_recent_key ← captured code.
    - Go to HELD.
- State HELD:
  - Row stays frozen. Extra columns pressed alongside the captured one are ignored.
  - When the captured column reads high, go to RELEASE with the counter cleared.
- State RELEASE:
  - Counts consecutive cycles in which the captured column reads high.
  - Captured column reads low again: return to HELD. No new registration occurs.
  - Counter reaches DEBOUNCE_CYCLES: go to SCAN, advancing to the next row.
- A key that is held can never register twice. A new press is only accepted after a full debounced release.
- Reset mid-operation: all state, counters, synchronizer flops and history return to their reset values immediately and asynchronously.

## Timing
- Reset values:
  - keypad_row = 4'b1110.
  - key_valid = 0.
  - most_recent_key = second_most_recent_key = 8'h00.
  - State SCAN, row 0, all counters 0.
- Column-to-decision latency: 2 cycles (synchronizer).
- Press registration: key_valid is high DEBOUNCE_CYCLES cycles after the cycle DEBOUNCE is entered, assuming a clean input.
  - History registers update on the same edge that raises key_valid, so the new values are visible in the key_valid cycle.
- Full scan period with no key pressed: 4·SCAN_DWELL cycles.
- All outputs are registered; nothing in this block is combinational from input to output.
- Counters are sized with $clog2(param+1) and saturate; they never wrap.

## Structure
- Package keypad_pkg holds:
  - the state enum: SCAN, DEBOUNCE, HELD, RELEASE;
  - the key_code_t typedef, logic [7:0];
  - the NO_KEY constant;
  - the row and column count (4).
- Sub-module sync_2ff, 4 bits wide, with async active-low reset to 1s (idle columns). It is reused for any other asynchronous input in the design.
- The FSM, counters and history registers live in keypad_scan_controller.

## Test plan
Bench parameters: SCAN_DWELL=4, DEBOUNCE_CYCLES=8.
- **Reset and idle scan:** assert reset low, release, no keys pressed.
  - keypad_row = 1110 out of reset, then steps 1101, 1011, 0111 every 4 cycles.
  - key_valid never asserts; both history outputs stay 8'h00.
- **Clean press:** press row 2, col 1 cleanly.
  - Scan freezes at keypad_row = 1011.
  - One key_valid pulse 8 cycles after DEBOUNCE entry.
  - most_recent_key = 8'h42, second_most_recent_key = 8'h00.
- **Bounce during debounce:** col 1 toggles high after 3 stable cycles.
  - No key_valid; scan resumes at row 3.
  - Then hold the key stable and confirm a single registration.
- **Long hold and re-press:** hold row 0, col 3 for 100 cycles, bounce the release once, then release cleanly.
  - Exactly one key_valid and most_recent_key = 8'h18.
  - Then press row 3, col 0: second_most_recent_key = 8'h18, most_recent_key = 8'h81.
- **Multiple columns at sample:** row 1 with cols 0 and 2 pressed together when the sample is taken.
  - Scan advances to row 2; no key is captured.
- **Reset mid-HELD:** pull reset low while the FSM is in HELD.
  - Outputs return to their reset values in the same cycle.
  - After reset is released the FSM restarts SCAN at row 0.
